mx_dot_product_vector_sequencer: RTL and testbench
==================================================

Name: mx_dot_product_vector_sequencer

Overview:
Synthesizable stimulus/checker for MX dot-product datapaths, replacing file-driven benches on FPGA/emulation targets. A vector RAM is preloaded through a load port and replayed to the DUT over a valid/ready handshake. Expected results are queued in order and compared against DUT results, which return at an arbitrary latency. The block reports pass/fail counts, the first failing index and a done flag, and is parametrised in block size, element/scale/result widths and vector depth.

Parameters:
BLOCK_SIZE, 32, elements per operand vector
ELEM_WIDTH, 8, bits per element
SCALE_WIDTH, 8, bits per shared scale
RESULT_WIDTH, 32, bits of DUT result (float32)
DEPTH, 16, vector RAM entries (power of 2)
EXP_DEPTH, 4, expected-result FIFO entries (power of 2)
CNT_WIDTH, 16, pass/fail counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ld_we  in  1  write vector entry (accepted only in IDLE/DONE)
ld_addr  in  log2(DEPTH)  entry address
ld_scale_a, ld_scale_b  in  SCALE_WIDTH  operand scales
ld_elems_a, ld_elems_b  in  BLOCK_SIZE*ELEM_WIDTH  packed elements, element i at [i*ELEM_WIDTH +: ELEM_WIDTH]
ld_exp_result  in  RESULT_WIDTH  expected result
ld_exp_flags  in  3  expected {unused, overflow, NaN}
start  in  1  begin run (accepted only in IDLE/DONE)
num_vectors  in  log2(DEPTH)+1  vectors per pass, sampled at start; 0 completes immediately
loop_en  in  1  replay continuously until stop
stop  in  1  end looping after current pass
out_valid  out  1  stimulus valid
out_ready  in  1  DUT accepts stimulus
scale_a, scale_b  out  SCALE_WIDTH  stimulus scales
elems_a, elems_b  out  BLOCK_SIZE*ELEM_WIDTH  stimulus elements
res_valid  in  1  DUT result valid (no backpressure)
res_value  in  RESULT_WIDTH  DUT result
res_flags  in  3  DUT {unused, overflow, NaN}
pass_cnt, fail_cnt  out  CNT_WIDTH  saturating counters
first_fail_idx  out  log2(DEPTH)  index of first mismatch
fail_seen  out  1  sticky mismatch
spurious_err  out  1  sticky: result arrived with FIFO empty
busy  out  1  state is RUN or DRAIN
done  out  1  state is DONE

Behaviour:
- Reset: all outputs 0, FSM IDLE, FIFO empty, issue index 0. RAM contents are not cleared. Reset mid-run aborts immediately, and out_valid is 0 in the following cycle.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE --start--> RUN. Counters, sticky flags, first_fail_idx and the FIFO are cleared on the same edge. num_vectors=0 goes to DONE directly.
  - RUN --last handshake of pass, loop_en=0 or stop seen--> DRAIN.
  - RUN --last handshake, loop_en=1 and no stop--> RUN, with the index wrapping to 0.
  - DRAIN --FIFO empty--> DONE.
- stop is latched sticky during RUN and cleared on start.
- Stimulus outputs are registered.
  - out_valid rises 1 cycle after start is accepted.
  - Data is held stable while out_valid && !out_ready.
  - After a handshake, the next entry is presented in the following cycle with no bubble.
  - out_valid is deasserted while the FIFO is full, and reasserts the cycle after a pop.
- On each handshake, push {exp_result, exp_flags, index} into the FIFO.
- On res_valid, pop the FIFO head and compare in the same cycle. Simultaneous push and pop when full is not possible because issue is stalled.
- Match rule:
  - res_flags must equal exp_flags.
  - If exp NaN flag = 1, the result value is don't-care.
  - Otherwise res_value must equal exp_result bit-exactly.
- Match increments pass_cnt. Mismatch increments fail_cnt and sets fail_seen; first_fail_idx is captured only when fail_seen was 0. Counters saturate at all-ones.
- res_valid with the FIFO empty (any state) sets spurious_err and changes no counter.
- ld_we and start are ignored in RUN/DRAIN.

Test Plan:
1. Load 3 entries, out_ready=1, DUT model with fixed 2-cycle latency, all results correct -> pass_cnt=3, fail_cnt=0, done 1 cycle after the 3rd result is compared.
2. Entry 1 result corrupted (0x3F800000 returned vs 0x40000000 expected) -> fail_cnt=1, first_fail_idx=1, fail_seen=1. A later corruption at index 2 leaves first_fail_idx=1.
3. out_ready toggling every cycle, latency 10 cycles, EXP_DEPTH=4 -> at most 4 outstanding transactions, out_valid drops while the FIFO is full, stimulus stable under stall, pass_cnt=num_vectors.
4. Expected NaN flag=1 with any res_value and matching flags -> pass. The same entry with res_flags=000 -> fail.
5. loop_en=1, num_vectors=2, stop asserted after 5 handshakes -> pass completes at 6 handshakes, then DRAIN, DONE, pass_cnt=6.
6. res_valid pulse while IDLE -> spurious_err=1. rst asserted mid-RUN -> next cycle out_valid=0, busy=0, counters 0; RAM replays the same vectors on the next start.

Source files
------------

// File: rtl/mx_dot_product_vector_sequencer.sv
// Replays preloaded operand vectors to an MX dot-product datapath over valid/ready and checks
// the returned results, in order, against a queue of expected values.
module mx_dot_product_vector_sequencer #(
  parameter int unsigned BLOCK_SIZE   = 32,
  parameter int unsigned ELEM_WIDTH   = 8,
  parameter int unsigned SCALE_WIDTH  = 8,
  parameter int unsigned RESULT_WIDTH = 32,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned EXP_DEPTH    = 4,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             ld_we,
  input  logic [$clog2(DEPTH)-1:0]         ld_addr,
  input  logic [SCALE_WIDTH-1:0]           ld_scale_a,
  input  logic [SCALE_WIDTH-1:0]           ld_scale_b,
  input  logic [BLOCK_SIZE*ELEM_WIDTH-1:0] ld_elems_a,
  input  logic [BLOCK_SIZE*ELEM_WIDTH-1:0] ld_elems_b,
  input  logic [RESULT_WIDTH-1:0]          ld_exp_result,
  input  logic [2:0]                       ld_exp_flags,
  input  logic                             start,
  input  logic [$clog2(DEPTH):0]           num_vectors,
  input  logic                             loop_en,
  input  logic                             stop,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [SCALE_WIDTH-1:0]           scale_a,
  output logic [SCALE_WIDTH-1:0]           scale_b,
  output logic [BLOCK_SIZE*ELEM_WIDTH-1:0] elems_a,
  output logic [BLOCK_SIZE*ELEM_WIDTH-1:0] elems_b,
  input  logic                             res_valid,
  input  logic [RESULT_WIDTH-1:0]          res_value,
  input  logic [2:0]                       res_flags,
  output logic [CNT_WIDTH-1:0]             pass_cnt,
  output logic [CNT_WIDTH-1:0]             fail_cnt,
  output logic [$clog2(DEPTH)-1:0]         first_fail_idx,
  output logic                             fail_seen,
  output logic                             spurious_err,
  output logic                             busy,
  output logic                             done
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned EAW = $clog2(EXP_DEPTH);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  // Vector RAM: written only while idle, never cleared by reset
  logic [SCALE_WIDTH-1:0]           ram_scale_a [DEPTH];
  logic [SCALE_WIDTH-1:0]           ram_scale_b [DEPTH];
  logic [BLOCK_SIZE*ELEM_WIDTH-1:0] ram_elems_a [DEPTH];
  logic [BLOCK_SIZE*ELEM_WIDTH-1:0] ram_elems_b [DEPTH];
  logic [RESULT_WIDTH-1:0]          ram_exp_res [DEPTH];
  logic [2:0]                       ram_exp_flg [DEPTH];

  // Expected-result FIFO
  logic [RESULT_WIDTH-1:0] fifo_res [EXP_DEPTH];
  logic [2:0]              fifo_flg [EXP_DEPTH];
  logic [AW-1:0]           fifo_idx [EXP_DEPTH];
  logic [EAW-1:0]          wr_q, rd_q;
  logic [EAW:0]            cnt_q, cnt_after;

  state_e                           state_q, state_d;
  logic [AW-1:0]                    idx_q, idx_d;
  logic [AW:0]                      num_q, num_d;
  logic                             stop_q, stop_d;
  logic                             out_valid_q, out_valid_d;
  logic                             load;
  logic [SCALE_WIDTH-1:0]           scale_a_q, scale_b_q;
  logic [BLOCK_SIZE*ELEM_WIDTH-1:0] elems_a_q, elems_b_q;
  logic [CNT_WIDTH-1:0]             pass_q, fail_q;
  logic [AW-1:0]                    first_fail_q;
  logic                             fail_seen_q, spurious_q;

  logic idle_like, start_acc, handshake, push, pop, last, stop_seen, has_room, match;

  assign idle_like = (state_q == StIdle) || (state_q == StDone);
  assign start_acc = start && idle_like;
  assign handshake = out_valid_q && out_ready;
  assign push      = handshake;
  assign pop       = res_valid && (cnt_q != '0);
  assign cnt_after = cnt_q + (EAW+1)'(push) - (EAW+1)'(pop);
  assign has_room  = cnt_after < (EAW+1)'(EXP_DEPTH);
  assign last      = ({1'b0, idx_q} == (num_q - (AW+1)'(1)));
  assign stop_seen = stop_q || stop;

  // NaN-expected entries only need matching flags
  assign match = (res_flags == fifo_flg[rd_q]) &&
                 (fifo_flg[rd_q][0] || (res_value == fifo_res[rd_q]));

  always_ff @(posedge clk) begin
    if (ld_we && idle_like) begin
      ram_scale_a[ld_addr] <= ld_scale_a;
      ram_scale_b[ld_addr] <= ld_scale_b;
      ram_elems_a[ld_addr] <= ld_elems_a;
      ram_elems_b[ld_addr] <= ld_elems_b;
      ram_exp_res[ld_addr] <= ld_exp_result;
      ram_exp_flg[ld_addr] <= ld_exp_flags;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    num_d       = num_q;
    stop_d      = stop_q;
    out_valid_d = out_valid_q;
    load        = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          stop_d  = 1'b0;
          idx_d   = '0;
          num_d   = num_vectors;
          state_d = (num_vectors == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (stop) stop_d = 1'b1;
        if (handshake) begin
          if (last && !(loop_en && !stop_seen)) begin
            state_d     = StDrain;
            out_valid_d = 1'b0;
          end else begin
            idx_d       = last ? '0 : idx_q + AW'(1);
            out_valid_d = has_room;
            load        = has_room;
          end
        end else if (!out_valid_q && has_room) begin
          out_valid_d = 1'b1;
          load        = 1'b1;
        end
      end
      StDrain: begin
        if (cnt_after == '0) state_d = StDone;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      num_q   <= '0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      num_q   <= num_d;
      stop_q  <= stop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      scale_a_q   <= '0;
      scale_b_q   <= '0;
      elems_a_q   <= '0;
      elems_b_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      if (load) begin
        scale_a_q <= ram_scale_a[idx_d];
        scale_b_q <= ram_scale_b[idx_d];
        elems_a_q <= ram_elems_a[idx_d];
        elems_b_q <= ram_elems_b[idx_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_res[wr_q] <= ram_exp_res[idx_q];
      fifo_flg[wr_q] <= ram_exp_flg[idx_q];
      fifo_idx[wr_q] <= idx_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + EAW'(1);
      if (pop) rd_q <= rd_q + EAW'(1);
      cnt_q <= cnt_after;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      pass_q       <= '0;
      fail_q       <= '0;
      first_fail_q <= '0;
      fail_seen_q  <= 1'b0;
      spurious_q   <= 1'b0;
    end else if (res_valid) begin
      if (cnt_q == '0) begin
        spurious_q <= 1'b1;
      end else if (match) begin
        if (pass_q != '1) pass_q <= pass_q + CNT_WIDTH'(1);
      end else begin
        if (fail_q != '1) fail_q <= fail_q + CNT_WIDTH'(1);
        if (!fail_seen_q) first_fail_q <= fifo_idx[rd_q];
        fail_seen_q <= 1'b1;
      end
    end
  end

  assign out_valid      = out_valid_q;
  assign scale_a        = scale_a_q;
  assign scale_b        = scale_b_q;
  assign elems_a        = elems_a_q;
  assign elems_b        = elems_b_q;
  assign pass_cnt       = pass_q;
  assign fail_cnt       = fail_q;
  assign first_fail_idx = first_fail_q;
  assign fail_seen      = fail_seen_q;
  assign spurious_err   = spurious_q;
  assign busy           = (state_q == StRun) || (state_q == StDrain);
  assign done           = (state_q == StDone);

endmodule

// File: tb/tb_mx_dot_product_vector_sequencer.sv
// Directed bench: a latency-configurable fake datapath answers each stimulus by its scale_a tag.
module tb_mx_dot_product_vector_sequencer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ld_we = 1'b0;
  logic [3:0]   ld_addr = '0;
  logic [7:0]   ld_scale_a = '0, ld_scale_b = '0;
  logic [255:0] ld_elems_a = '0, ld_elems_b = '0;
  logic [31:0]  ld_exp_result = '0;
  logic [2:0]   ld_exp_flags = '0;
  logic         start = 1'b0;
  logic [4:0]   num_vectors = '0;
  logic         loop_en = 1'b0, stop = 1'b0;
  logic         out_valid, out_ready = 1'b1;
  logic [7:0]   scale_a, scale_b;
  logic [255:0] elems_a, elems_b;
  logic         res_valid = 1'b0;
  logic [31:0]  res_value = '0;
  logic [2:0]   res_flags = '0;
  logic [15:0]  pass_cnt, fail_cnt;
  logic [3:0]   first_fail_idx;
  logic         fail_seen, spurious_err, busy, done;

  mx_dot_product_vector_sequencer dut (
    .clk(clk), .rst(rst), .ld_we(ld_we), .ld_addr(ld_addr),
    .ld_scale_a(ld_scale_a), .ld_scale_b(ld_scale_b),
    .ld_elems_a(ld_elems_a), .ld_elems_b(ld_elems_b),
    .ld_exp_result(ld_exp_result), .ld_exp_flags(ld_exp_flags),
    .start(start), .num_vectors(num_vectors), .loop_en(loop_en), .stop(stop),
    .out_valid(out_valid), .out_ready(out_ready),
    .scale_a(scale_a), .scale_b(scale_b), .elems_a(elems_a), .elems_b(elems_b),
    .res_valid(res_valid), .res_value(res_value), .res_flags(res_flags),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .first_fail_idx(first_fail_idx),
    .fail_seen(fail_seen), .spurious_err(spurious_err), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [255:0] pat(input int i, input bit b);
    logic [255:0] v;
    for (int j = 0; j < 32; j++) v[j*8 +: 8] = 8'(i * 16 + j) ^ (b ? 8'hA5 : 8'h00);
    return v;
  endfunction

  function automatic logic [31:0] ev(input int i);
    return (i == 3) ? 32'h7FC0_0000 : 32'h3FF0_0000 + 32'(i) * 32'h0010_0000;
  endfunction

  function automatic logic [2:0] ef(input int i);
    if (i == 3) return 3'b001;
    if (i == 6) return 3'b010;
    return 3'b000;
  endfunction

  // Fake datapath: responses indexed by the scale_a tag of the accepted stimulus
  typedef struct {
    int          due;
    logic [31:0] val;
    logic [2:0]  flg;
  } pend_t;

  pend_t       pq[$];
  logic [31:0] resp_val [16];
  logic [2:0]  resp_flg [16];
  int          lat = 2;
  int          cyc = 0;
  int          inject_req = 0;
  int          inject_ack = 0;

  always @(posedge clk) begin
    bit         hs_s, rst_s;
    logic [7:0] tag;
    hs_s  = out_valid && out_ready;
    rst_s = rst;
    tag   = scale_a;
    #1;
    cyc++;
    res_valid = 1'b0;
    res_value = '0;
    res_flags = '0;
    if (rst_s) pq.delete();
    else if (hs_s) pq.push_back('{cyc + lat, resp_val[tag[3:0]], resp_flg[tag[3:0]]});
    if (inject_req != inject_ack) begin
      inject_ack = inject_req;
      res_valid  = 1'b1;
      res_value  = 32'h0000_1234;
    end else if (pq.size() != 0 && pq[0].due <= cyc) begin
      res_valid = 1'b1;
      res_value = pq[0].val;
      res_flags = pq[0].flg;
      void'(pq.pop_front());
    end
  end

  // Corrupt masked entries: wrong value, or cleared flags for the NaN entry
  task automatic set_resp(input logic [7:0] mask);
    logic [2:0] f;
    for (int i = 0; i < 16; i++) begin
      f = ef(i);
      resp_flg[i] = f;
      resp_val[i] = f[0] ? 32'hDEAD_BEEF : ev(i);
      if (i < 8 && mask[i]) begin
        if (f[0]) resp_flg[i] = 3'b000;
        else resp_val[i] = 32'h3F80_0000;
      end
    end
  endtask

  task automatic start_run(input int num);
    num_vectors = 5'(num);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit tog);
    int k = 0;
    while (!done && k < budget) begin
      out_ready = tog ? ~out_ready : 1'b1;
      step();
      k++;
    end
    out_ready = 1'b1;
    check("done_reached", done, 1);
  endtask

  typedef struct {
    int         num;
    int         lat;
    bit         tog;
    logic [7:0] mask;
    int         e_pass;
    int         e_fail;
    int         e_ffi;
    bit         e_fs;
  } scen_t;

  scen_t sc[8];

  initial begin
    int          nres, k, hs_n, pop_n, outst, p_out, max_out, full_seen;
    int          viol_full, viol_stable, viol_re;
    bit          p_valid, p_ready, p_res, p_hs;
    logic [7:0]  p_scale;
    logic [255:0] p_elems;
    logic [31:0] hist;

    sc[0] = '{3, 2,  1'b0, 8'h00, 3, 0, 0, 1'b0};
    sc[1] = '{3, 2,  1'b0, 8'h02, 2, 1, 1, 1'b1};
    sc[2] = '{3, 2,  1'b0, 8'h06, 1, 2, 1, 1'b1};
    sc[3] = '{8, 10, 1'b1, 8'h00, 8, 0, 0, 1'b0};
    sc[4] = '{4, 3,  1'b0, 8'h00, 4, 0, 0, 1'b0};
    sc[5] = '{4, 3,  1'b0, 8'h08, 3, 1, 3, 1'b1};
    sc[6] = '{0, 2,  1'b0, 8'h00, 0, 0, 0, 1'b0};
    sc[7] = '{8, 1,  1'b1, 8'hA0, 6, 2, 5, 1'b1};
    set_resp(8'h00);

    repeat (3) step();
    rst = 1'b0;
    step();
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass_cnt, 0);
    check("rst_fail", fail_cnt, 0);
    check("rst_fail_seen", fail_seen, 0);
    check("rst_ffi", first_fail_idx, 0);
    check("rst_spurious", spurious_err, 0);
    check("rst_scale_a", scale_a, 0);
    check("rst_elems_a", elems_a == '0, 1);

    inject_req++;
    step();
    step();
    check("idle_spurious", spurious_err, 1);
    check("idle_spurious_pass", pass_cnt, 0);
    check("idle_spurious_fail", fail_cnt, 0);

    for (int i = 0; i < 8; i++) begin
      ld_we = 1'b1;
      ld_addr = 4'(i);
      ld_scale_a = 8'(i);
      ld_scale_b = 8'(i * 3);
      ld_elems_a = pat(i, 1'b0);
      ld_elems_b = pat(i, 1'b1);
      ld_exp_result = ev(i);
      ld_exp_flags = ef(i);
      step();
    end
    ld_we = 1'b0;

    // Three vectors, fixed latency: first valid timing and done timing
    lat = 2;
    out_ready = 1'b1;
    start_run(3);
    check("a_valid_at_start", out_valid, 0);
    check("a_busy", busy, 1);
    check("a_spurious_cleared", spurious_err, 0);
    step();
    check("a_valid_rise", out_valid, 1);
    check("a_scale_a0", scale_a, 0);
    check("a_scale_b0", scale_b, 0);
    check("a_elems_a0", elems_a == pat(0, 1'b0), 1);
    check("a_elems_b0", elems_b == pat(0, 1'b1), 1);
    nres = 0;
    k = 0;
    while (nres < 3 && k < 100) begin
      step();
      k++;
      if (res_valid) nres++;
    end
    check("a_results_seen", nres, 3);
    check("a_done_pending", done, 0);
    check("a_drain_busy", busy, 1);
    check("a_drain_valid", out_valid, 0);
    step();
    check("a_done", done, 1);
    check("a_pass", pass_cnt, 3);
    check("a_fail", fail_cnt, 0);

    for (int i = 0; i < 8; i++) begin
      set_resp(sc[i].mask);
      lat = sc[i].lat;
      out_ready = 1'b1;
      start_run(sc[i].num);
      wait_done(2000, sc[i].tog);
      check($sformatf("s%0d_pass", i), pass_cnt, 64'(sc[i].e_pass));
      check($sformatf("s%0d_fail", i), fail_cnt, 64'(sc[i].e_fail));
      check($sformatf("s%0d_fail_seen", i), fail_seen, 64'(sc[i].e_fs));
      check($sformatf("s%0d_ffi", i), first_fail_idx, 64'(sc[i].e_ffi));
      check($sformatf("s%0d_spurious", i), spurious_err, 0);
      check($sformatf("s%0d_busy", i), busy, 0);
    end

    // Toggling ready with long latency: FIFO-full stall and stability under backpressure
    set_resp(8'h00);
    lat = 10;
    hs_n = 0; pop_n = 0; max_out = 0; full_seen = 0;
    viol_full = 0; viol_stable = 0; viol_re = 0;
    start_run(8);
    out_ready = 1'b0;
    k = 0;
    while (!done && k < 2000) begin
      p_valid = out_valid;
      p_ready = out_ready;
      p_scale = scale_a;
      p_elems = elems_a;
      p_res   = res_valid;
      p_out   = hs_n - pop_n;
      step();
      k++;
      if (p_valid && p_ready) hs_n++;
      if (p_res) pop_n++;
      outst = hs_n - pop_n;
      if (outst > max_out) max_out = outst;
      if (outst == 4) begin
        full_seen++;
        if (out_valid) viol_full++;
      end
      if (p_valid && !p_ready && !(out_valid && scale_a == p_scale && elems_a == p_elems))
        viol_stable++;
      if (!p_valid && p_out == 4 && p_res && hs_n < 8 && !out_valid) viol_re++;
      out_ready = ~out_ready;
    end
    out_ready = 1'b1;
    check("b_done", done, 1);
    check("b_max_outstanding", max_out, 4);
    check("b_full_seen", full_seen != 0, 1);
    check("b_valid_while_full", viol_full, 0);
    check("b_stall_unstable", viol_stable, 0);
    check("b_no_reassert", viol_re, 0);
    check("b_pass", pass_cnt, 8);
    check("b_fail", fail_cnt, 0);

    // Looping two vectors, stop raised after the fifth handshake
    set_resp(8'h00);
    lat = 2;
    out_ready = 1'b1;
    loop_en = 1'b1;
    hs_n = 0;
    hist = '0;
    start_run(2);
    k = 0;
    while (!done && k < 300) begin
      p_hs = out_valid && out_ready;
      p_scale = scale_a;
      step();
      k++;
      if (p_hs) begin
        hs_n++;
        hist = (hist << 4) | 32'(p_scale[3:0]);
      end
      stop = (hs_n == 5);
    end
    stop = 1'b0;
    loop_en = 1'b0;
    check("c_done", done, 1);
    check("c_handshakes", hs_n, 6);
    check("c_index_order", hist, 32'h0001_0101);
    check("c_pass", pass_cnt, 6);
    check("c_fail", fail_cnt, 0);

    // Reset mid-run, then replay from the retained RAM
    lat = 3;
    start_run(8);
    repeat (4) step();
    check("d_running", out_valid, 1);
    rst = 1'b1;
    step();
    check("d_rst_valid", out_valid, 0);
    check("d_rst_busy", busy, 0);
    check("d_rst_done", done, 0);
    check("d_rst_pass", pass_cnt, 0);
    check("d_rst_fail", fail_cnt, 0);
    rst = 1'b0;
    step();
    lat = 2;
    start_run(3);
    wait_done(2000, 1'b0);
    check("d_replay_pass", pass_cnt, 3);
    check("d_replay_fail", fail_cnt, 0);
    check("d_replay_spurious", spurious_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d",
             n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
